riscv_l2_write_buffer: RTL and testbench

Posted-write buffer and read-miss sequencer between the L1 data cache's L2-side port and the L2/memory request bus. Stores complete to L1 one cycle after acceptance and drain to memory in the background in FIFO order. Reads are serviced by store-to-load forwarding from the buffer, or by a single outstanding memory read that bypasses queued writes.

---
 rtl/riscv_l2_write_buffer.sv | 193 +++++++++++++++++++
 tb/tb_riscv_l2_write_buffer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_l2_write_buffer.sv
// Posted-write buffer with store-to-load forwarding and a single outstanding
// read-miss sequencer between the L1 data cache and the L2/memory request bus.
module riscv_l2_write_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] l1_addr,
  input  logic              l1_read,
  input  logic              l1_write,
  input  logic [DATA_W-1:0] l1_wdata,
  output logic [DATA_W-1:0] l1_rdata,
  output logic              l1_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_empty,
  output logic              wb_full
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned WORD_W = ADDR_W - 2;

  typedef enum logic [1:0] {IDLE, DRAIN, RD_REQ, RD_WAIT} state_t;

  state_t state;

  logic [DEPTH-1:0]  ent_valid;
  logic [WORD_W-1:0] ent_word [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;

  logic [WORD_W-1:0] req_word;
  logic              unused_addr_lsb;
  logic              accepting;
  logic              rd_go;
  logic              wr_go;
  logic              hit;
  logic [PTR_W-1:0]  hit_idx;
  logic [PTR_W-1:0]  scan_idx;
  logic              head_busy;
  logic              coalesce;
  logic              alloc;
  logic              rd_hit;
  logic              rd_miss_go;
  logic              pop;
  logic              full;
  logic [DATA_W-1:0] head_wdata;

  assign req_word        = l1_addr[ADDR_W-1:2];
  assign unused_addr_lsb = ^l1_addr[1:0];

  // Requests are only looked at while no completion pulse is showing, and
  // never while a memory read is in flight.
  assign accepting = !l1_ready && (state == IDLE || state == DRAIN);
  assign rd_go     = accepting && l1_read;
  assign wr_go     = accepting && l1_write && !l1_read;
  assign full      = (count == CNT_W'(DEPTH));

  // Scan from oldest to youngest so the last match wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_idx = head + PTR_W'(i);
      if (ent_valid[scan_idx] && ent_word[scan_idx] == req_word) begin
        hit     = 1'b1;
        hit_idx = scan_idx;
      end
    end
  end

  assign head_busy  = (state == DRAIN) && hit && (hit_idx == head);
  assign coalesce   = wr_go && hit && !head_busy;
  assign alloc      = wr_go && !coalesce && !full;
  assign rd_hit     = rd_go && hit;
  assign rd_miss_go = rd_go && !hit && (state == IDLE);
  assign pop        = (state == DRAIN) && mem_gnt;

  // Coalescing into the head in the same cycle the drain is launched must
  // present the new data, not the stale stored word.
  assign head_wdata = (coalesce && hit_idx == head) ? l1_wdata : ent_data[head];

  always_comb begin
    count_nxt = count;
    case ({alloc, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_word[i] <= '0;
        ent_data[i] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PTR_W'(1);
      end
      if (coalesce) begin
        ent_data[hit_idx] <= l1_wdata;
      end
      if (alloc) begin
        ent_valid[tail] <= 1'b1;
        ent_word[tail]  <= req_word;
        ent_data[tail]  <= l1_wdata;
        tail            <= tail + PTR_W'(1);
      end
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      l1_ready  <= 1'b0;
      l1_rdata  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_empty  <= 1'b1;
      wb_full   <= 1'b0;
    end else begin
      l1_ready <= coalesce || alloc || rd_hit;
      if (rd_hit) begin
        l1_rdata <= ent_data[hit_idx];
      end
      wb_empty <= (count_nxt == '0);
      wb_full  <= (count_nxt == CNT_W'(DEPTH));

      case (state)
        IDLE: begin
          if (rd_miss_go) begin
            state    <= RD_REQ;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {req_word, 2'b00};
          end else if (count != '0) begin
            state     <= DRAIN;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {ent_word[head], 2'b00};
            mem_wdata <= head_wdata;
          end
        end
        DRAIN: begin
          if (mem_gnt) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
        end
        RD_REQ: begin
          if (mem_gnt) begin
            state   <= RD_WAIT;
            mem_req <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (mem_rvalid) begin
            state    <= IDLE;
            l1_rdata <= mem_rdata;
            l1_ready <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_l2_write_buffer.sv
// Directed bench for riscv_l2_write_buffer: inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_riscv_l2_write_buffer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] l1_addr;
  logic              l1_read;
  logic              l1_write;
  logic [DATA_W-1:0] l1_wdata;
  logic [DATA_W-1:0] l1_rdata;
  logic              l1_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              wb_empty;
  logic              wb_full;

  int checks   = 0;
  int failures = 0;
  int lat;
  logic [DATA_W-1:0] rdat;

  always #5 clk = ~clk;

  riscv_l2_write_buffer #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .l1_addr   (l1_addr),
    .l1_read   (l1_read),
    .l1_write  (l1_write),
    .l1_wdata  (l1_wdata),
    .l1_rdata  (l1_rdata),
    .l1_ready  (l1_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .wb_empty  (wb_empty),
    .wb_full   (wb_full)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present a write until completion, drop it in the ready cycle, then let
  // the ready pulse pass. lat = cycles from presentation to ready (0 = timeout).
  task automatic wr(input logic [31:0] a, input logic [31:0] d, output int lt);
    l1_addr  = a;
    l1_wdata = d;
    l1_write = 1'b1;
    lt       = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (l1_ready) begin
        lt = i;
        break;
      end
    end
    l1_write = 1'b0;
    tick();
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output int lt);
    l1_addr = a;
    l1_read = 1'b1;
    lt      = 0;
    d       = '0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (l1_ready) begin
        lt = i;
        d  = l1_rdata;
        break;
      end
    end
    l1_read = 1'b0;
    tick();
  endtask

  task automatic drain_all(input string tag);
    logic done;
    done    = 1'b0;
    mem_gnt = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (wb_empty && !mem_req) begin
        done = 1'b1;
        break;
      end
    end
    mem_gnt = 1'b0;
    check(tag, done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    l1_addr    = '0;
    l1_read    = 1'b0;
    l1_write   = 1'b0;
    l1_wdata   = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    repeat (3) tick();

    check("rst_l1_ready", l1_ready, 1'b0);
    check("rst_l1_rdata", l1_rdata, 32'h0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_wb_empty", wb_empty, 1'b1);
    check("rst_wb_full", wb_full, 1'b0);
    rst_n = 1'b1;
    tick();

    // Single posted write, grant withheld.
    l1_addr  = 32'h1000;
    l1_wdata = 32'hAAAA_0001;
    l1_write = 1'b1;
    tick();
    check("t1_ready_t1", l1_ready, 1'b1);
    check("t1_not_empty", wb_empty, 1'b0);
    check("t1_req_not_yet", mem_req, 1'b0);
    l1_write = 1'b0;
    tick();
    check("t1_req", mem_req, 1'b1);
    check("t1_we", mem_we, 1'b1);
    check("t1_addr", mem_addr, 32'h1000);
    check("t1_wdata", mem_wdata, 32'hAAAA_0001);
    check("t1_ready_pulse", l1_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_req_hold", mem_req, 1'b1);
      check("t1_addr_hold", mem_addr, 32'h1000);
      check("t1_wdata_hold", mem_wdata, 32'hAAAA_0001);
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("t1_req_drop", mem_req, 1'b0);
    check("t1_empty_after", wb_empty, 1'b1);
    tick();
    check("t1_req_stays_low", mem_req, 1'b0);

    // Forwarding from the buffer, no memory read.
    wr(32'h1000, 32'hAAAA_0001, lat);
    check("t2_wr0_lat", lat, 1);
    wr(32'h1004, 32'hBBBB_0002, lat);
    check("t2_wr1_lat", lat, 1);
    rd(32'h1000, rdat, lat);
    check("t2_rd_lat", lat, 1);
    check("t2_rd_data", rdat, 32'hAAAA_0001);
    check("t2_still_write", mem_we, 1'b1);
    check("t2_still_addr", mem_addr, 32'h1000);
    rd(32'h1006, rdat, lat);
    check("t2_rd_lsb_ignored", rdat, 32'hBBBB_0002);
    drain_all("t2_drain");

    // Fill to full, stall, release by one pop.
    for (int i = 0; i < 4; i++) begin
      wr(32'h4000 + 32'(i * 4), 32'h40 + 32'(i), lat);
      check("t3_fill_lat", lat, 1);
    end
    check("t3_full", wb_full, 1'b1);
    l1_addr  = 32'h4010;
    l1_wdata = 32'h55;
    l1_write = 1'b1;
    tick();
    check("t3_stall0", l1_ready, 1'b0);
    tick();
    check("t3_stall1", l1_ready, 1'b0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("t3_stall_at_pop", l1_ready, 1'b0);
    check("t3_not_full_after_pop", wb_full, 1'b0);
    tick();
    check("t3_accept_after_pop", l1_ready, 1'b1);
    check("t3_full_again", wb_full, 1'b1);
    check("t3_next_drain_addr", mem_addr, 32'h4004);
    l1_write = 1'b0;
    tick();
    drain_all("t3_drain");

    // Coalescing, and the head-in-drain exception.
    wr(32'h1000, 32'h1, lat);
    wr(32'h2000, 32'h11, lat);
    wr(32'h2000, 32'h22, lat);
    check("t4_coalesce_lat", lat, 1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("t4_gap", mem_req, 1'b0);
    check("t4_not_empty", wb_empty, 1'b0);
    tick();
    check("t4_drain2_addr", mem_addr, 32'h2000);
    check("t4_drain2_data", mem_wdata, 32'h22);
    wr(32'h2000, 32'h33, lat);
    check("t4_head_busy_lat", lat, 1);
    check("t4_head_data_stable", mem_wdata, 32'h22);
    rd(32'h2000, rdat, lat);
    check("t4_fwd_youngest", rdat, 32'h33);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("t4_second_entry_left", wb_empty, 1'b0);
    tick();
    check("t4_drain3_addr", mem_addr, 32'h2000);
    check("t4_drain3_data", mem_wdata, 32'h33);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("t4_empty", wb_empty, 1'b1);
    tick();

    // Read miss bypasses a queued write.
    wr(32'h5000, 32'h50, lat);
    wr(32'h5004, 32'h54, lat);
    l1_addr = 32'h3000;
    l1_read = 1'b1;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("t5_miss_waits", l1_ready, 1'b0);
    tick();
    check("t5_rd_req", mem_req, 1'b1);
    check("t5_rd_we", mem_we, 1'b0);
    check("t5_rd_addr", mem_addr, 32'h3000);
    tick();
    tick();
    check("t5_rd_addr_hold", mem_addr, 32'h3000);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("t5_req_drop", mem_req, 1'b0);
    tick();
    check("t5_no_drain_in_wait", mem_req, 1'b0);
    tick();
    check("t5_no_ready_yet", l1_ready, 1'b0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    l1_read    = 1'b0;
    check("t5_ready", l1_ready, 1'b1);
    check("t5_rdata", l1_rdata, 32'hDEAD_BEEF);
    tick();
    check("t5_drain_resumes", mem_req, 1'b1);
    check("t5_drain_addr", mem_addr, 32'h5004);
    check("t5_drain_data", mem_wdata, 32'h54);
    drain_all("t5_drain");

    // Stray rvalid while idle, then minimum-latency miss.
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h7777_7777;
    tick();
    mem_rvalid = 1'b0;
    check("t5b_stray_rvalid", l1_ready, 1'b0);
    l1_addr = 32'h3100;
    l1_read = 1'b1;
    mem_gnt = 1'b1;
    tick();
    check("t5b_req", mem_req, 1'b1);
    check("t5b_we", mem_we, 1'b0);
    tick();
    mem_gnt    = 1'b0;
    check("t5b_req_low", mem_req, 1'b0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0BAD_F00D;
    tick();
    mem_rvalid = 1'b0;
    l1_read    = 1'b0;
    check("t5b_ready", l1_ready, 1'b1);
    check("t5b_rdata", l1_rdata, 32'h0BAD_F00D);
    tick();

    // Reset while waiting for read data.
    wr(32'h6000, 32'h60, lat);
    wr(32'h6004, 32'h64, lat);
    l1_addr = 32'h3200;
    l1_read = 1'b1;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    tick();
    check("t6_rd_req", mem_req, 1'b1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("t6_buffered", wb_empty, 1'b0);
    rst_n   = 1'b0;
    l1_read = 1'b0;
    #1;
    check("t6_async_empty", wb_empty, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    tick();
    mem_rvalid = 1'b0;
    check("t6_l1_ready", l1_ready, 1'b0);
    check("t6_l1_rdata", l1_rdata, 32'h0);
    check("t6_mem_req", mem_req, 1'b0);
    check("t6_mem_we", mem_we, 1'b0);
    check("t6_mem_addr", mem_addr, 32'h0);
    check("t6_mem_wdata", mem_wdata, 32'h0);
    check("t6_wb_empty", wb_empty, 1'b1);
    check("t6_wb_full", wb_full, 1'b0);
    tick();
    check("t6_stays_idle", mem_req, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
